// File: rtl/ht_29_encoder_pkg.sv
// Shared types and constants for the table-29 serial Huffman encoder.
//   MAX_BITS   longest codeword in the pair table
//   LINBITS    width of the escape field appended when an index is 15
//   FRAME_BITS width of the left-aligned frame shift register
//   ht_axis()  per-axis magnitude split into table index, linbits and sign
package ht_pkg;

    localparam int MAX_BITS   = 12;
    localparam int LINBITS    = 9;
    localparam int FRAME_BITS = 32;

    localparam logic [16:0] ESC_IDX = 17'd15;
    localparam logic [16:0] LIN_MAX = 17'((1 << LINBITS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } ht_enc_state_t;

    typedef struct packed {
        logic [MAX_BITS-1:0] code;  // right-aligned codeword
        logic [3:0]          len;
    } ht_code_t;

    typedef struct packed {
        logic [3:0]         idx;
        logic [LINBITS-1:0] lin;
        logic               esc;    // idx == 15, linbits follow the codeword
        logic               nz;     // magnitude non-zero, sign bit is sent
        logic               sgn;
        logic               sat;    // escape value clipped to LIN_MAX
    } ht_axis_t;

    // 17-bit magnitude so that -32768 becomes +32768 instead of wrapping.
    function automatic ht_axis_t ht_axis(input logic [15:0] v);
        ht_axis_t    r;
        logic [16:0] a;
        logic [16:0] d;
        a     = v[15] ? (~{v[15], v} + 17'd1) : {1'b0, v};
        d     = a - ESC_IDX;
        r.sgn = v[15];
        r.nz  = (a != 17'd0);
        if (a < ESC_IDX) begin
            r.idx = a[3:0];
            r.esc = 1'b0;
            r.lin = '0;
            r.sat = 1'b0;
        end else begin
            r.idx = 4'hf;
            r.esc = 1'b1;
            if (d > LIN_MAX) begin
                r.lin = '1;
                r.sat = 1'b1;
            end else begin
                r.lin = d[LINBITS-1:0];
                r.sat = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ht_29_encoder_if.sv
// Pair-in / bit-out handshake bundle of the table-29 encoder.
//   axiiv/axiir    input pair valid / ready
//   x_val, y_val   signed spectral pair
//   axiov, axiod   serial bit valid / bit (MSB first)
//   ovf            pulse: accepted pair had an escape value clipped
interface ht_29_encoder_if;

    logic        axiiv;
    logic        axiir;
    logic [15:0] x_val;
    logic [15:0] y_val;
    logic        axiov;
    logic        axiod;
    logic        ovf;

    modport master (
        output axiiv, x_val, y_val,
        input  axiir, axiov, axiod, ovf
    );

    modport slave (
        input  axiiv, x_val, y_val,
        output axiir, axiov, axiod, ovf
    );

endinterface

// File: rtl/ht_29_encoder_rom.sv
// Combinational codeword table for big-value table pair 29 (shares the
// codes of table 24). Row index is idx_x, column index is idx_y.
//   idx_x_i, idx_y_i  4-bit table indices
//   code_o            right-aligned codeword and its length
module ht_29_enc_rom
    import ht_pkg::*;
(
    input  logic [3:0] idx_x_i,
    input  logic [3:0] idx_y_i,
    output ht_code_t   code_o
);

    localparam logic [11:0] CODE_TAB [256] = '{
        12'h00f, 12'h00d, 12'h02e, 12'h050, 12'h092, 12'h106, 12'h0f8, 12'h1b2, 12'h1aa, 12'h29d, 12'h28d, 12'h289, 12'h26d, 12'h205, 12'h408, 12'h058,
        12'h00e, 12'h00c, 12'h015, 12'h026, 12'h047, 12'h082, 12'h07a, 12'h0d8, 12'h0d1, 12'h0c6, 12'h147, 12'h159, 12'h13f, 12'h129, 12'h117, 12'h02a,
        12'h02f, 12'h016, 12'h029, 12'h04a, 12'h044, 12'h080, 12'h078, 12'h0dd, 12'h0cf, 12'h0c2, 12'h0b6, 12'h154, 12'h13b, 12'h127, 12'h21d, 12'h012,
        12'h051, 12'h027, 12'h04b, 12'h046, 12'h086, 12'h07d, 12'h074, 12'h0dc, 12'h0cc, 12'h0be, 12'h0b2, 12'h145, 12'h137, 12'h125, 12'h10f, 12'h010,
        12'h093, 12'h048, 12'h045, 12'h087, 12'h07f, 12'h076, 12'h070, 12'h0d2, 12'h0c8, 12'h0bc, 12'h160, 12'h143, 12'h132, 12'h11d, 12'h21c, 12'h00e,
        12'h107, 12'h042, 12'h081, 12'h07e, 12'h077, 12'h072, 12'h0d6, 12'h0ca, 12'h0c0, 12'h0b4, 12'h155, 12'h13d, 12'h12d, 12'h119, 12'h106, 12'h00c,
        12'h0f9, 12'h07b, 12'h079, 12'h075, 12'h071, 12'h0d7, 12'h0ce, 12'h0c3, 12'h0b9, 12'h15b, 12'h14a, 12'h134, 12'h123, 12'h110, 12'h208, 12'h00a,
        12'h1b3, 12'h073, 12'h06f, 12'h06d, 12'h0d3, 12'h0cb, 12'h0c4, 12'h0bb, 12'h161, 12'h14c, 12'h139, 12'h12a, 12'h11b, 12'h213, 12'h17d, 12'h011,
        12'h1ab, 12'h0d4, 12'h0d0, 12'h0cd, 12'h0c9, 12'h0c1, 12'h0ba, 12'h0b1, 12'h0a9, 12'h140, 12'h12f, 12'h11e, 12'h10c, 12'h202, 12'h179, 12'h010,
        12'h14f, 12'h0c7, 12'h0c5, 12'h0bf, 12'h0bd, 12'h0b5, 12'h0ae, 12'h14d, 12'h141, 12'h131, 12'h121, 12'h113, 12'h209, 12'h17b, 12'h173, 12'h00b,
        12'h29c, 12'h0b8, 12'h0b7, 12'h0b3, 12'h0af, 12'h158, 12'h14b, 12'h13a, 12'h130, 12'h122, 12'h115, 12'h212, 12'h17f, 12'h175, 12'h16e, 12'h00a,
        12'h28c, 12'h15a, 12'h0ab, 12'h0a8, 12'h0a4, 12'h13e, 12'h135, 12'h12b, 12'h11f, 12'h114, 12'h107, 12'h201, 12'h177, 12'h170, 12'h16a, 12'h006,
        12'h288, 12'h142, 12'h13c, 12'h138, 12'h133, 12'h12e, 12'h124, 12'h11c, 12'h10d, 12'h105, 12'h200, 12'h178, 12'h172, 12'h16c, 12'h167, 12'h004,
        12'h26c, 12'h12c, 12'h128, 12'h126, 12'h120, 12'h11a, 12'h111, 12'h10a, 12'h203, 12'h17c, 12'h176, 12'h171, 12'h16d, 12'h169, 12'h165, 12'h002,
        12'h409, 12'h118, 12'h116, 12'h112, 12'h10b, 12'h108, 12'h103, 12'h17e, 12'h17a, 12'h174, 12'h16f, 12'h16b, 12'h168, 12'h166, 12'h164, 12'h000,
        12'h02b, 12'h014, 12'h013, 12'h011, 12'h00f, 12'h00d, 12'h00b, 12'h009, 12'h007, 12'h006, 12'h004, 12'h007, 12'h005, 12'h003, 12'h001, 12'h003
    };

    localparam logic [3:0] LEN_TAB [256] = '{
        4'd4,  4'd4,  4'd6,  4'd7,  4'd8,  4'd9,  4'd9,  4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd12, 4'd9,
        4'd4,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd8,
        4'd6,  4'd5,  4'd6,  4'd7,  4'd7,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd11, 4'd7,
        4'd7,  4'd6,  4'd7,  4'd7,  4'd8,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd7,
        4'd8,  4'd7,  4'd7,  4'd8,  4'd8,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd7,
        4'd9,  4'd7,  4'd8,  4'd8,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd7,
        4'd9,  4'd8,  4'd8,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd7,
        4'd10, 4'd8,  4'd8,  4'd8,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd8,
        4'd10, 4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd8,
        4'd10, 4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd8,
        4'd11, 4'd9,  4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11, 4'd8,
        4'd11, 4'd10, 4'd9,  4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11, 4'd8,
        4'd11, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd8,
        4'd11, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd8,
        4'd12, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd8,
        4'd8,  4'd7,  4'd7,  4'd7,  4'd7,  4'd7,  4'd7,  4'd7,  4'd7,  4'd7,  4'd7,  4'd8,  4'd8,  4'd8,  4'd8,  4'd4
    };

    always_comb begin
        code_o.code = CODE_TAB[{idx_x_i, idx_y_i}];
        code_o.len  = LEN_TAB[{idx_x_i, idx_y_i}];
    end

endmodule

// File: rtl/ht_29_encoder.sv
// Serial Huffman encoder, table pair 29 (9 linbits). Takes one signed
// (x, y) pair per handshake and shifts out codeword, x linbits, x sign,
// y linbits, y sign, one bit per clock, MSB first.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     slave side of ht_29_encoder_if (pair in, bits out, ovf)
//
// state | meaning
// IDLE  | waiting for a pair, ready high
// LOAD  | table lookup and frame packing, ovf reported here
// SHIFT | one frame bit per cycle; ready high on the last bit
module ht_29_encoder
    import ht_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    ht_29_encoder_if.slave    bus
);

    ht_enc_state_t         state_q, state_d;
    logic [15:0]           x_q, x_d;
    logic [15:0]           y_q, y_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [5:0]            cnt_q, cnt_d;

    ht_axis_t              ax_x, ax_y;
    ht_code_t              rom_code;
    logic [FRAME_BITS-1:0] frame;
    logic [5:0]            frame_len;
    logic [6:0]            frame_shamt;

    logic                  ready, bit_vld, bit_val, ovf;

    assign ax_x = ht_axis(x_q);
    assign ax_y = ht_axis(y_q);

    ht_29_enc_rom u_rom (
        .idx_x_i (ax_x.idx),
        .idx_y_i (ax_y.idx),
        .code_o  (rom_code)
    );

    // Frame is built right-aligned by appending fields, then moved to the
    // top of the register so the shifter always sends bit 31.
    always_comb begin
        frame     = {20'd0, rom_code.code};
        frame_len = {2'd0, rom_code.len};
        if (ax_x.esc) begin
            frame     = {frame[FRAME_BITS-LINBITS-1:0], ax_x.lin};
            frame_len = frame_len + 6'd9;
        end
        if (ax_x.nz) begin
            frame     = {frame[FRAME_BITS-2:0], ax_x.sgn};
            frame_len = frame_len + 6'd1;
        end
        if (ax_y.esc) begin
            frame     = {frame[FRAME_BITS-LINBITS-1:0], ax_y.lin};
            frame_len = frame_len + 6'd9;
        end
        if (ax_y.nz) begin
            frame     = {frame[FRAME_BITS-2:0], ax_y.sgn};
            frame_len = frame_len + 6'd1;
        end
        // 7 bits so a full 32-bit frame gives a shift of 0, not a wrap.
        frame_shamt = 7'd32 - {1'b0, frame_len};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        bit_vld = 1'b0;
        bit_val = 1'b0;
        ovf     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.axiiv) begin
                    x_d     = bus.x_val;
                    y_d     = bus.y_val;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_d    = frame << frame_shamt;
                cnt_d   = frame_len;
                ovf     = ax_x.sat | ax_y.sat;
                state_d = SHIFT;
            end
            SHIFT: begin
                bit_vld = 1'b1;
                bit_val = sr_q[FRAME_BITS-1];
                sr_d    = {sr_q[FRAME_BITS-2:0], 1'b0};
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    ready = 1'b1;
                    if (bus.axiiv) begin
                        x_d     = bus.x_val;
                        y_d     = bus.y_val;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready is gated by reset so it reads 0 while reset is held, even
    // though the state register already sits in IDLE.
    assign bus.axiir = ready & rst_n;
    assign bus.axiov = bit_vld;
    assign bus.axiod = bit_val;
    assign bus.ovf   = ovf;

endmodule

// File: tb/tb_ht_29_encoder.sv
module tb_ht_29_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ht_29_encoder_if bus ();

    ht_29_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Presents one pair, then records latency, frame bits and ovf pulses.
    task automatic send_pair(input logic [15:0] x, input logic [15:0] y,
                             output logic [31:0] bits, output int n,
                             output int lat, output int ovf_cnt);
        int guard;
        bits = '0; n = 0; lat = 0; ovf_cnt = 0; guard = 0;
        @(negedge clk);
        bus.x_val = x;
        bus.y_val = y;
        bus.axiiv = 1'b1;
        while (!bus.axiir && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.axiiv = 1'b0;
        if (bus.ovf) ovf_cnt++;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.axiov && lat < 50);
        while (bus.axiov && n < 40) begin
            bits = {bits[30:0], bus.axiod};
            n++;
            if (bus.ovf) ovf_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.axiov !== 1'b0) begin errors++; $display("FAIL rst_axiov: got %b expected 0", bus.axiov); end
        checks++; if (bus.axiod !== 1'b0) begin errors++; $display("FAIL rst_axiod: got %b expected 0", bus.axiod); end
        checks++; if (bus.axiir !== 1'b0) begin errors++; $display("FAIL rst_axiir: got %b expected 0", bus.axiir); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.axiir !== 1'b1) begin errors++; $display("FAIL idle_axiir: got %b expected 1", bus.axiir); end
        checks++; if (bus.axiov !== 1'b0) begin errors++; $display("FAIL idle_axiov: got %b expected 0", bus.axiov); end
    endtask

    task automatic test_small_values();
        logic [15:0] xs [5];
        logic [15:0] ys [5];
        logic [31:0] eb [5];
        int          ns [5];
        logic [31:0] bits;
        int          n, lat, oc;
        xs = '{16'd0, 16'(-1), 16'd0, 16'd14, 16'd0};
        ys = '{16'd0, 16'd0, 16'd1, 16'd0, 16'(-2)};
        eb = '{32'b1111, 32'b1110_1, 32'b1101_0, 32'b0100_0000_1001_0, 32'b101110_1};
        ns = '{4, 5, 5, 13, 7};
        for (int k = 0; k < 5; k++) begin
            send_pair(xs[k], ys[k], bits, n, lat, oc);
            checks++; if (lat !== 2) begin errors++; $display("FAIL small_lat[%0d]: got %0d expected 2", k, lat); end
            checks++; if (n !== ns[k]) begin errors++; $display("FAIL small_len[%0d]: got %0d expected %0d", k, n, ns[k]); end
            checks++; if (bits !== eb[k]) begin errors++; $display("FAIL small_bits[%0d]: got %b expected %b", k, bits, eb[k]); end
            checks++; if (oc !== 0) begin errors++; $display("FAIL small_ovf[%0d]: got %0d expected 0", k, oc); end
        end
    endtask

    task automatic test_escape();
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        logic [31:0] eb [4];
        int          ns [4];
        logic [31:0] bits;
        int          n, lat, oc;
        xs = '{16'd15, 16'd20, 16'(-15), 16'd0};
        ys = '{16'd15, 16'(-3), 16'd0, 16'd15};
        eb = '{32'b0011_000000000_0_000000000_0,
               32'b0010001_000000101_0_1,
               32'b00101011_000000000_1,
               32'b001011000_000000000_0};
        ns = '{24, 18, 18, 19};
        for (int k = 0; k < 4; k++) begin
            send_pair(xs[k], ys[k], bits, n, lat, oc);
            checks++; if (lat !== 2) begin errors++; $display("FAIL esc_lat[%0d]: got %0d expected 2", k, lat); end
            checks++; if (n !== ns[k]) begin errors++; $display("FAIL esc_len[%0d]: got %0d expected %0d", k, n, ns[k]); end
            checks++; if (bits !== eb[k]) begin errors++; $display("FAIL esc_bits[%0d]: got %b expected %b", k, bits, eb[k]); end
            checks++; if (oc !== 0) begin errors++; $display("FAIL esc_ovf[%0d]: got %0d expected 0", k, oc); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] xs [5];
        logic [15:0] ys [5];
        logic [31:0] eb [5];
        int          ns [5];
        int          eo [5];
        logic [31:0] bits;
        int          n, lat, oc;
        xs = '{16'd526, 16'd527, 16'd600, 16'h8000, 16'd0};
        ys = '{16'd0, 16'd0, 16'd0, 16'd0, 16'(-1000)};
        eb = '{32'b00101011_111111111_0, 32'b00101011_111111111_0,
               32'b00101011_111111111_0, 32'b00101011_111111111_1,
               32'b001011000_111111111_1};
        ns = '{18, 18, 18, 18, 19};
        eo = '{0, 1, 1, 1, 1};
        for (int k = 0; k < 5; k++) begin
            send_pair(xs[k], ys[k], bits, n, lat, oc);
            checks++; if (n !== ns[k]) begin errors++; $display("FAIL sat_len[%0d]: got %0d expected %0d", k, n, ns[k]); end
            checks++; if (bits !== eb[k]) begin errors++; $display("FAIL sat_bits[%0d]: got %b expected %b", k, bits, eb[k]); end
            checks++; if (oc !== eo[k]) begin errors++; $display("FAIL sat_ovf[%0d]: got %0d pulses expected %0d", k, oc, eo[k]); end
        end
    endtask

    // Escape-only pairs: every frame is 0011 + 9 lin + sign + 9 lin + sign,
    // so the bench decodes them directly and checks the 1-cycle gaps.
    task automatic test_back_to_back();
        localparam int NP  = 6;
        localparam int CAP = 200;
        logic [15:0] xs [NP];
        logic [15:0] ys [NP];
        logic        v_arr [CAP];
        logic        d_arr [CAP];
        logic [23:0] fr;
        logic [15:0] dx, dy;
        int          i, start, len, gstart, mag;
        for (int k = 0; k < NP; k++) begin
            mag   = int'($urandom_range(526, 15));
            xs[k] = ($urandom_range(1, 0) == 1) ? 16'(-mag) : 16'(mag);
            mag   = int'($urandom_range(526, 15));
            ys[k] = ($urandom_range(1, 0) == 1) ? 16'(-mag) : 16'(mag);
        end
        fork
            begin
                int guard;
                for (int k = 0; k < NP; k++) begin
                    guard = 0;
                    @(negedge clk);
                    bus.x_val = xs[k];
                    bus.y_val = ys[k];
                    bus.axiiv = 1'b1;
                    while (!bus.axiir && guard < 100) begin
                        @(negedge clk);
                        guard++;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.axiiv = 1'b0;
            end
            begin
                for (int c = 0; c < CAP; c++) begin
                    @(negedge clk);
                    v_arr[c] = bus.axiov;
                    d_arr[c] = bus.axiod;
                end
            end
        join
        i = 0;
        while (i < CAP && !v_arr[i]) i++;
        for (int f = 0; f < NP; f++) begin
            start = i;
            fr    = '0;
            while (i < CAP && v_arr[i]) begin
                if (i - start < 24) fr = {fr[22:0], d_arr[i]};
                i++;
            end
            len = i - start;
            dx  = 16'(15 + int'(fr[19:11]));
            if (fr[10]) dx = -dx;
            dy  = 16'(15 + int'(fr[9:1]));
            if (fr[0]) dy = -dy;
            checks++; if (len !== 24) begin errors++; $display("FAIL b2b_len[%0d]: got %0d expected 24", f, len); end
            checks++; if (fr[23:20] !== 4'b0011) begin errors++; $display("FAIL b2b_code[%0d]: got %b expected 0011", f, fr[23:20]); end
            checks++; if (dx !== xs[f]) begin errors++; $display("FAIL b2b_x[%0d]: got %0d expected %0d", f, $signed(dx), $signed(xs[f])); end
            checks++; if (dy !== ys[f]) begin errors++; $display("FAIL b2b_y[%0d]: got %0d expected %0d", f, $signed(dy), $signed(ys[f])); end
            if (f < NP - 1) begin
                gstart = i;
                while (i < CAP && !v_arr[i]) i++;
                checks++; if (i - gstart !== 1) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d expected 1", f, i - gstart); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] bits;
        int          n, lat, oc, guard;
        guard = 0;
        @(negedge clk);
        bus.x_val = 16'd15;
        bus.y_val = 16'd15;
        bus.axiiv = 1'b1;
        while (!bus.axiir && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.axiiv = 1'b0;
        guard = 0;
        while (!bus.axiov && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        checks++; if (bus.axiov !== 1'b1) begin errors++; $display("FAIL mid_active: got %b expected 1", bus.axiov); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.axiov !== 1'b0) begin errors++; $display("FAIL mid_rst_axiov: got %b expected 0", bus.axiov); end
        checks++; if (bus.axiir !== 1'b0) begin errors++; $display("FAIL mid_rst_axiir: got %b expected 0", bus.axiir); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.axiov !== 1'b0) begin errors++; $display("FAIL mid_discard: got %b expected 0", bus.axiov); end
        checks++; if (bus.axiir !== 1'b1) begin errors++; $display("FAIL mid_idle_rdy: got %b expected 1", bus.axiir); end
        send_pair(16'd20, 16'(-3), bits, n, lat, oc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_rst_lat: got %0d expected 2", lat); end
        checks++; if (n !== 18) begin errors++; $display("FAIL post_rst_len: got %0d expected 18", n); end
        checks++; if (bits !== 32'b0010001_000000101_0_1) begin errors++; $display("FAIL post_rst_bits: got %b expected %b", bits, 32'b0010001_000000101_0_1); end
    endtask

    initial begin
        bus.axiiv = 1'b0;
        bus.x_val = '0;
        bus.y_val = '0;
        test_reset();
        test_small_values();
        test_escape();
        test_saturation();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
